// File: rtl/decode_stage.sv
// Registered, handshaked RV32I-subset decoder with a per-instruction micro-step counter.
// Optional BEQ/BNE support is enabled with `define BRANCH_EN.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 2,
  parameter int ALU_LAST = 1,
  parameter int MEM_LAST = 2,
  parameter int BR_LAST  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic             step_adv,
  output logic             op_valid,
  output logic [8:0]       op_onehot,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [CNT_W-1:0] step,
  output logic             last_step,
  output logic             halted,
  output logic [31:0]      illegal_instr
);

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  typedef struct packed {
    logic            legal;
    logic [8:0]      onehot;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } dec_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t          state;
  dec_t            dec;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;
  logic [CNT_W-1:0] last_idx;
  logic            accept;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i = XLEN'($signed(instruction[31:20]));
  assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
  assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                instruction[30:21], 1'b0}));
`ifdef BRANCH_EN
  logic [XLEN-1:0] imm_b;
  assign imm_b = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                instruction[11:8], 1'b0}));
`endif

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec = '0;
    unique case (opcode)
      OPC_R: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) dec.onehot[0] = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0100000) dec.onehot[1] = 1'b1;
        dec.rs1 = instruction[19:15];
        dec.rs2 = instruction[24:20];
        dec.rd  = instruction[11:7];
      end
      OPC_LOAD: begin
        dec.onehot[2] = (funct3 == 3'b010);
        dec.imm = imm_i;
        dec.rs1 = instruction[19:15];
        dec.rd  = instruction[11:7];
      end
      OPC_STORE: begin
        dec.onehot[3] = (funct3 == 3'b010);
        dec.imm = imm_s;
        dec.rs1 = instruction[19:15];
        dec.rs2 = instruction[24:20];
      end
      OPC_OPIMM: begin
        dec.onehot[4] = (funct3 == 3'b000);
        dec.imm = imm_i;
        dec.rs1 = instruction[19:15];
        dec.rd  = instruction[11:7];
      end
      OPC_LUI: begin
        dec.onehot[5] = 1'b1;
        dec.imm = imm_u;
        dec.rd  = instruction[11:7];
      end
      OPC_JAL: begin
        dec.onehot[6] = 1'b1;
        dec.imm = imm_j;
        dec.rd  = instruction[11:7];
      end
`ifdef BRANCH_EN
      OPC_BRANCH: begin
        dec.onehot[7] = (funct3 == 3'b000);
        dec.onehot[8] = (funct3 == 3'b001);
        dec.imm = imm_b;
        dec.rs1 = instruction[19:15];
        dec.rs2 = instruction[24:20];
      end
`endif
      default: ;
    endcase
    dec.legal = |dec.onehot;
    // Illegal words latch all-zero fields, so the load path needs no extra muxing.
    if (!dec.legal) dec = '0;
  end

  always_comb begin
    last_idx = CNT_W'(ALU_LAST);
    if (op_onehot[2] || op_onehot[3]) last_idx = CNT_W'(MEM_LAST);
    if (op_onehot[7] || op_onehot[8]) last_idx = CNT_W'(BR_LAST);
  end

  assign last_step = op_valid && (step == last_idx);
  assign in_ready  = !flush && (state == IDLE || (state == EXEC && last_step && step_adv));
  assign accept    = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_valid      <= 1'b0;
      op_onehot     <= '0;
      imm           <= '0;
      rs1           <= '0;
      rs2           <= '0;
      rd            <= '0;
      step          <= '0;
      halted        <= 1'b0;
      illegal_instr <= '0;
    end else if (flush && state != HALT) begin
      state     <= IDLE;
      op_valid  <= 1'b0;
      op_onehot <= '0;
      imm       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      step      <= '0;
    end else if (accept) begin
      op_valid  <= dec.legal;
      op_onehot <= dec.onehot;
      imm       <= dec.imm;
      rs1       <= dec.rs1;
      rs2       <= dec.rs2;
      rd        <= dec.rd;
      step      <= '0;
      if (dec.legal) begin
        state <= EXEC;
      end else begin
        state         <= HALT;
        halted        <= 1'b1;
        illegal_instr <= instruction;
      end
    end else if (state == EXEC && step_adv) begin
      if (last_step) begin
        // Retire with nothing waiting: drop back to IDLE with cleared fields.
        state     <= IDLE;
        op_valid  <= 1'b0;
        op_onehot <= '0;
        imm       <= '0;
        rs1       <= '0;
        rs2       <= '0;
        rd        <= '0;
        step      <= '0;
      end else begin
        step <= step + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan steps followed by random
// traffic, all compared against a behavioural model of the decode/step rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic        step_adv = 1'b0;
  logic        op_valid;
  logic [8:0]  op_onehot;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  step;
  logic        last_step;
  logic        halted;
  logic [31:0] illegal_instr;

  int total = 0;
  int bad   = 0;

  // Model state: the instruction currently held (if any) and the halt record.
  bit          m_busy, m_halt;
  int          m_op, m_step, m_last, m_rs1, m_rs2, m_rd;
  logic [31:0] m_imm, m_ill;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .step_adv(step_adv), .op_valid(op_valid),
    .op_onehot(op_onehot), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .step(step),
    .last_step(last_step), .halted(halted), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA field rules, using integer shifts for sign extension.
  function automatic void ref_decode(input logic [31:0] w, output bit ok, output int op,
                                     output logic [31:0] im, output int r1, output int r2,
                                     output int rdd, output int last);
    int sw;
    int f3, f7;
    sw = $signed(w);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    op = -1; im = '0; r1 = 0; r2 = 0; rdd = 0; last = 1;
    case (w[6:0])
      7'h33: begin
        if (f3 == 0 && f7 == 0) op = 0;
        else if (f3 == 0 && f7 == 32) op = 1;
        r1 = int'(w[19:15]); r2 = int'(w[24:20]); rdd = int'(w[11:7]);
      end
      7'h03: if (f3 == 2) begin
        op = 2; im = sw >>> 20; r1 = int'(w[19:15]); rdd = int'(w[11:7]); last = 2;
      end
      7'h23: if (f3 == 2) begin
        op = 3; im = ((sw >>> 25) * 32) + int'(w[11:7]);
        r1 = int'(w[19:15]); r2 = int'(w[24:20]); last = 2;
      end
      7'h13: if (f3 == 0) begin
        op = 4; im = sw >>> 20; r1 = int'(w[19:15]); rdd = int'(w[11:7]);
      end
      7'h37: begin op = 5; im = w & 32'hFFFF_F000; rdd = int'(w[11:7]); end
      7'h6F: begin
        op = 6; rdd = int'(w[11:7]);
        im = ((sw >>> 31) * (1 << 20)) + int'(w[19:12]) * (1 << 12)
             + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2;
      end
`ifdef BRANCH_EN
      7'h63: if (f3 == 0 || f3 == 1) begin
        op = 7 + f3; r1 = int'(w[19:15]); r2 = int'(w[24:20]); last = 2;
        im = ((sw >>> 31) * (1 << 12)) + int'(w[7]) * (1 << 11)
             + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
`endif
      default: ;
    endcase
    ok = (op >= 0);
    if (!ok) begin im = '0; r1 = 0; r2 = 0; rdd = 0; end
  endfunction

  task automatic model_clear();
    m_busy = 0; m_op = 0; m_imm = '0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_step = 0; m_last = 1;
  endtask

  task automatic model_reset();
    model_clear();
    m_halt = 0; m_ill = '0;
  endtask

  task automatic check_regs(input string p);
    check({p, ".op_valid"}, 32'(op_valid), 32'(m_busy));
    check({p, ".op_onehot"}, 32'(op_onehot), m_busy ? (32'd1 << m_op) : 32'd0);
    check({p, ".imm"}, imm, m_imm);
    check({p, ".rs1"}, 32'(rs1), m_rs1);
    check({p, ".rs2"}, 32'(rs2), m_rs2);
    check({p, ".rd"}, 32'(rd), m_rd);
    check({p, ".step"}, 32'(step), m_step);
    check({p, ".halted"}, 32'(halted), 32'(m_halt));
    check({p, ".illegal_instr"}, illegal_instr, m_ill);
  endtask

  // One clock: drive at the falling edge, check handshake outputs, then registered fields.
  task automatic cycle(input logic v, input logic [31:0] w, input logic adv, input logic fl);
    bit rdy, ok;
    bit at_last;
    int op, r1, r2, rdd, last;
    logic [31:0] im;
    @(negedge clk);
    in_valid = v; instruction = w; step_adv = adv; flush = fl;
    #1;
    at_last = m_busy && (m_step == m_last);
    rdy = !fl && !m_halt && (!m_busy || (at_last && adv));
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("last_step", 32'(last_step), 32'(at_last));
    @(posedge clk);
    if (fl && !m_halt) begin
      model_clear();
    end else if (v && rdy) begin
      ref_decode(w, ok, op, im, r1, r2, rdd, last);
      if (ok) begin
        m_busy = 1; m_op = op; m_imm = im; m_rs1 = r1; m_rs2 = r2; m_rd = rdd;
        m_step = 0; m_last = last;
      end else begin
        model_clear();
        m_halt = 1; m_ill = w;
      end
    end else if (m_busy && adv) begin
      if (at_last) model_clear();
      else m_step++;
    end
    #1;
    check_regs("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; step_adv = 1'b0;
    #1;
    model_reset();
    check_regs("rst");
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 19))
      0, 1, 13, 14: begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h00; end
      2:            begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h20; end
      3, 4:         begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
      5, 6:         begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
      9:            r[6:0] = 7'h37;
      10:           r[6:0] = 7'h6F;
      11, 12:       begin r[6:0] = 7'h63; r[14:12] = 3'($urandom_range(0, 1)); end
      15:           r[6:0] = 7'h63;
      16:           ;
      17:           r = '0;
      default:      begin r[6:0] = 7'h13; r[14:12] = 3'd0; end
    endcase
    return r;
  endfunction

  localparam logic [31:0] W_ADD  = 32'h0020_81B3;
  localparam logic [31:0] W_ADDI = 32'hFFF0_0293;
  localparam logic [31:0] W_SW   = 32'hFE20_AE23;
  localparam logic [31:0] W_LW   = 32'h0080_A203;
  localparam logic [31:0] W_BEQ  = 32'h0020_8463;

  initial begin
    model_reset();
    do_reset();

    // ADD then back-to-back ADDI on the ADD's last step.
    cycle(1, W_ADD, 1, 0);
    check("add.onehot", 32'(op_onehot), 32'h001);
    check("add.rd", 32'(rd), 32'd3);
    cycle(0, '0, 1, 0);
    cycle(1, W_ADDI, 1, 0);
    check("addi.imm", imm, 32'hFFFF_FFFF);
    check("addi.rd", 32'(rd), 32'd5);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // SW with the datapath stalled, then walked to its final step.
    cycle(1, W_SW, 0, 0);
    check("sw.imm", imm, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0);
    check("sw.hold", 32'(step), 32'd0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    check("sw.step2", 32'(step), 32'd2);
    cycle(0, '0, 1, 0);
    check("sw.retire", 32'(op_valid), 32'd0);

    // Flush during LW step 1 with a new word offered.
    cycle(1, W_LW, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(1, W_ADD, 0, 1);
    check("flush.op_valid", 32'(op_valid), 32'd0);
    cycle(0, '0, 0, 0);

    // Branch word: decoded with BRANCH_EN, otherwise a halt.
    cycle(1, W_BEQ, 1, 0);
`ifdef BRANCH_EN
    check("beq.onehot", 32'(op_onehot), 32'h080);
    check("beq.imm", imm, 32'd8);
`else
    check("beq.halt", 32'(halted), 32'd1);
`endif
    do_reset();

    // All-zero word halts; flush and new words are ignored afterwards.
    cycle(1, '0, 1, 0);
    check("zero.halted", 32'(halted), 32'd1);
    cycle(1, W_ADD, 1, 1);
    cycle(1, W_ADD, 1, 0);
    check("halt.sticky", 32'(halted), 32'd1);
    do_reset();

    // Reset in the middle of an instruction.
    cycle(1, W_SW, 1, 0);
    cycle(0, '0, 1, 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
      else
        cycle($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked successor to the combinational instruction decoder.
- Accepts one RV32I-subset instruction per handshake, latches its decoded fields, and sequences a per-instruction micro-step counter that the datapath advances.
- Sign-extends all immediates per the RISC-V formats.
- Detects illegal encodings and parks in a sticky HALT state.
- Sits between the instruction fetch register and the execute/control FSM.

Parameters:
- XLEN, 32, width of the immediate output.
- CNT_W, 2, width of the step counter.
- ALU_LAST, 1, final step index for ADD/SUB/ADDI/LUI/JAL.
- MEM_LAST, 2, final step index for LW/SW.
- BR_LAST, 2, final step index for BEQ/BNE (used only with BRANCH_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current instruction.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept (combinational).
- instruction  in  32  raw instruction word.
- step_adv  in  1  datapath completed the current step.
- op_valid  out  1  latched fields are valid.
- op_onehot  out  9  one-hot op: bit0 ADD, 1 SUB, 2 LW, 3 SW, 4 ADDI, 5 LUI, 6 JAL, 7 BEQ, 8 BNE.
- imm  out  XLEN  sign-extended immediate.
- rs1, rs2, rd  out  5 each  register indices; 0 when unused by the op.
- step  out  CNT_W  current micro-step index.
- last_step  out  1  op_valid and step equals the op's final index.
- halted  out  1  sticky illegal-instruction halt.
- illegal_instr  out  32  word that caused the halt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE.
  - op_valid, op_onehot, imm, rs1, rs2, rd, step, halted, illegal_instr all 0.
- States: IDLE, EXEC, HALT.
- in_ready = !flush & (IDLE | (EXEC & last_step & step_adv)). It is 0 in HALT.
- Accept (in_valid & in_ready), legal word:
  - Next edge: fields latched, op_valid=1, step=0, state EXEC.
  - Latency is 1 cycle.
- Accept, illegal word:
  - Next edge: state HALT, halted=1, illegal_instr=word, op_valid=0, fields 0.
- Decode:
  - Opcodes: R 0110011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, LUI 0110111, JAL 1101111, BRANCH 1100011.
  - ADD: funct3 000, funct7 0000000. SUB: funct3 000, funct7 0100000. LW/SW: funct3 010. ADDI: funct3 000.
  - Any other opcode/funct combination is illegal. 32'h0 is illegal.
- Immediates (all sign-extended to XLEN):
  - I-type: [31:20].
  - S-type: {[31:25],[11:7]}.
  - U-type: {[31:12],12'b0}.
  - J-type: {[31],[19:12],[20],[30:21],1'b0}.
  - R-type: imm=0.
- Field use:
  - rs1 used by R/LW/SW/ADDI/B.
  - rs2 used by R/SW/B.
  - rd used by R/LW/ADDI/LUI/JAL.
- EXEC:
  - Fields stay frozen regardless of the instruction input.
  - step_adv=1 and not last_step: step+1.
  - step_adv=0: hold.
  - last_step & step_adv & in_valid: back-to-back accept, no bubble.
  - last_step & step_adv & !in_valid: return to IDLE, op_valid=0, fields cleared to 0.
- flush (priority below reset, above all else):
  - From IDLE/EXEC: go to IDLE, clear fields and step.
  - An instruction offered in the same cycle is not accepted.
  - Ignored in HALT.
- HALT exits only through rst_n.
- Reset mid-EXEC: immediate return to reset values.
- step never exceeds the op's final index. There is no wrap-around.

Optional Feature:
- Macro: BRANCH_EN.
- Defined:
  - BRANCH funct3 000 → BEQ (bit7), funct3 001 → BNE (bit8).
  - imm = B-type {[31],[7],[30:25],[11:8],1'b0}, sign-extended.
  - rd=0; final index BR_LAST.
  - Other BRANCH funct3 values are illegal.
- Undefined: BRANCH opcode is illegal, and op_onehot bits 7 and 8 are tied to 0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), step_adv=1 → next cycle op_onehot=9'h001, rs1=1, rs2=2, rd=3, imm=0. last_step on step 1. in_ready high the same cycle.
- ADDI x5,x0,-1 (0xFFF00293) → imm=0xFFFFFFFF, rd=5, rs1=0, rs2=0.
- SW x2,-4(x1) (0xFE20AE23), step_adv held 0 for 3 cycles, then 1 → step frozen at 0, then 0→1→2. imm=0xFFFFFFFC, rd=0. Returns to IDLE with op_valid=0.
- 0x00000000 offered → next cycle halted=1, illegal_instr=0, in_ready=0. flush and a new ADD are ignored until rst_n pulses low.
- flush asserted with in_valid during EXEC step 1 of LW → IDLE, op_valid=0, offered word not accepted.
- BRANCH_EN: BEQ x1,x2,+8 (0x00208463) → op_onehot=9'h080, imm=8, rd=0. Without BRANCH_EN the same word → halted=1.
